// File: rtl/ddr_init_sequencer_if.sv
// Handshake bundle between the DDR init sequencer and the LPDDR4 hard controller / fabric.
// master: the sequencer side; slave: the controller/fabric side driving lock and cfg_done.
interface ddr_init_sequencer_if;
    logic       init_start;
    logic       ddr_pll_lock;
    logic       cfg_done;
    logic       ddr_pll_rstn;
    logic       phy_rstn;
    logic       ctrl_rstn;
    logic       cfg_reset;
    logic       cfg_start;
    logic       cfg_sel;
    logic       regARESETn;
    logic       axi0_ARESETn;
    logic       axi1_ARESETn;
    logic       init_done;
    logic       init_error;
    logic [1:0] err_code;
    logic [3:0] state_o;

    modport master (
        input  init_start, ddr_pll_lock, cfg_done,
        output ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_reset, cfg_start, cfg_sel,
        output regARESETn, axi0_ARESETn, axi1_ARESETn, init_done, init_error, err_code, state_o
    );

    modport slave (
        output init_start, ddr_pll_lock, cfg_done,
        input  ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_reset, cfg_start, cfg_sel,
        input  regARESETn, axi0_ARESETn, axi1_ARESETn, init_done, init_error, err_code, state_o
    );
endinterface

// File: rtl/ddr_init_sequencer.sv
// Power-up/recovery sequencer for the LPDDR4 controller: PLL, PHY/ctrl, cfg handshake, AXI resets.
// Define DDR_INIT_TIMEOUT_EN to enable the PLL-lock and cfg_done timeouts (error codes 1 and 2).
module ddr_init_sequencer #(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned RST_HOLD_CYCLES = 32,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned CFG_TIMEOUT     = 65535,
    parameter bit          CFG_SEL_VAL     = 1'b0
) (
    input logic                  regACLK,
    input logic                  reset,
    ddr_init_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StPllRst  = 4'd1,
        StPllLock = 4'd2,
        StRstRel  = 4'd3,
        StCfgWait = 4'd4,
        StReady   = 4'd5,
        StError   = 4'd6
    } state_t;

    typedef struct packed {
        logic pll_rstn;
        logic core_rstn;
        logic cfg_reset;
        logic cfg_start;
        logic axi_rstn;
        logic done;
    } outs_t;

    localparam logic [15:0] PllLoad  = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] HoldLoad = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] LockLoad = (LOCK_TIMEOUT == 0) ? 16'd0 : 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] CfgLoad  = (CFG_TIMEOUT == 0) ? 16'd0 : 16'(CFG_TIMEOUT - 1);

    // Output levels that hold for the whole time the FSM sits in a given state.
    function automatic outs_t outs_of(state_t s);
        outs_t o;
        o.pll_rstn  = s inside {StPllLock, StRstRel, StCfgWait, StReady};
        o.core_rstn = s inside {StRstRel, StCfgWait, StReady};
        o.cfg_reset = !(s inside {StCfgWait, StReady});
        o.cfg_start = (s == StCfgWait);
        o.axi_rstn  = (s == StReady);
        o.done      = (s == StReady);
        return o;
    endfunction

    logic        lock_meta, lock_sync, done_meta, done_sync;
    logic        cfg_sel_q;
    state_t      state;
    logic [15:0] cnt;
    outs_t       outs;
    logic        init_error_q;
    logic [1:0]  err_code_q;
    logic        abort;

    always_ff @(posedge regACLK or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            cfg_sel_q <= CFG_SEL_VAL;
        end else begin
            lock_meta <= bus.ddr_pll_lock;
            lock_sync <= lock_meta;
            done_meta <= bus.cfg_done;
            done_sync <= done_meta;
            cfg_sel_q <= CFG_SEL_VAL;
        end
    end

    assign abort = (state inside {StPllRst, StPllLock, StRstRel, StCfgWait, StReady}) &&
                   !bus.init_start;

    always_ff @(posedge regACLK or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            cnt          <= '0;
            outs         <= outs_of(StIdle);
            init_error_q <= 1'b0;
            err_code_q   <= 2'd0;
        end else if (abort) begin
            state <= StIdle;
            outs  <= outs_of(StIdle);
            cnt   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.init_start) begin
                        state        <= StPllRst;
                        outs         <= outs_of(StPllRst);
                        cnt          <= PllLoad;
                        init_error_q <= 1'b0;
                        err_code_q   <= 2'd0;
                    end
                end
                StPllRst: begin
                    if (cnt == '0) begin
                        state <= StPllLock;
                        outs  <= outs_of(StPllLock);
                        cnt   <= LockLoad;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                StPllLock: begin
                    // Lock beats a timeout landing on the same edge.
                    if (lock_sync) begin
                        state <= StRstRel;
                        outs  <= outs_of(StRstRel);
                        cnt   <= HoldLoad;
                    end
`ifdef DDR_INIT_TIMEOUT_EN
                    else if (cnt == '0) begin
                        state        <= StError;
                        outs         <= outs_of(StError);
                        cnt          <= '0;
                        init_error_q <= 1'b1;
                        err_code_q   <= 2'd1;
                    end
`endif
                    else if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                StRstRel: begin
                    if (cnt == '0) begin
                        state <= StCfgWait;
                        outs  <= outs_of(StCfgWait);
                        cnt   <= CfgLoad;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                StCfgWait: begin
                    if (done_sync) begin
                        state <= StReady;
                        outs  <= outs_of(StReady);
                        cnt   <= '0;
                    end
`ifdef DDR_INIT_TIMEOUT_EN
                    else if (cnt == '0) begin
                        state        <= StError;
                        outs         <= outs_of(StError);
                        cnt          <= '0;
                        init_error_q <= 1'b1;
                        err_code_q   <= 2'd2;
                    end
`endif
                    else if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                StReady: begin
                    if (!lock_sync) begin
                        state        <= StError;
                        outs         <= outs_of(StError);
                        cnt          <= '0;
                        init_error_q <= 1'b1;
                        err_code_q   <= 2'd3;
                    end
                end
                StError: begin
                    // Retry needs init_start to go low first.
                    if (!bus.init_start) begin
                        state <= StIdle;
                        outs  <= outs_of(StIdle);
                        cnt   <= '0;
                    end
                end
                default: begin
                    state        <= StError;
                    outs         <= outs_of(StError);
                    cnt          <= '0;
                    init_error_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ddr_pll_rstn = outs.pll_rstn;
    assign bus.phy_rstn     = outs.core_rstn;
    assign bus.ctrl_rstn    = outs.core_rstn;
    assign bus.cfg_reset    = outs.cfg_reset;
    assign bus.cfg_start    = outs.cfg_start;
    assign bus.cfg_sel      = cfg_sel_q;
    assign bus.regARESETn   = outs.axi_rstn;
    assign bus.axi0_ARESETn = outs.axi_rstn;
    assign bus.axi1_ARESETn = outs.axi_rstn;
    assign bus.init_done    = outs.done;
    assign bus.init_error   = init_error_q;
    assign bus.err_code     = err_code_q;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Directed plus randomized bench for ddr_init_sequencer, checked every cycle against a
// timestamp-based phase model; timeout scenarios run only when DDR_INIT_TIMEOUT_EN is defined.
module tb_ddr_init_sequencer;
    localparam int P  = 4;
    localparam int H  = 8;
    localparam int LT = 100;
    localparam int CT = 100;
`ifdef DDR_INIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ddr_init_sequencer_if bus ();

    ddr_init_sequencer #(
        .PLL_RST_CYCLES (P),
        .RST_HOLD_CYCLES(H),
        .LOCK_TIMEOUT   (LT),
        .CFG_TIMEOUT    (CT),
        .CFG_SEL_VAL    (1'b0)
    ) dut (
        .regACLK(clk),
        .reset  (rst),
        .bus    (bus)
    );

    // Model: phase number, entry timestamp, error flags, and the last two raw samples of the
    // asynchronous inputs (what the FSM sees is whatever was present two edges earlier).
    int         ph;
    int         cyc;
    int         t_ent;
    logic       m_errf;
    logic [1:0] m_err;
    logic       lk1, lk2, dn1, dn2;

    task automatic model_reset();
        ph = 0; t_ent = cyc; m_errf = 1'b0; m_err = 2'd0;
        lk1 = 1'b0; lk2 = 1'b0; dn1 = 1'b0; dn2 = 1'b0;
    endtask

    task automatic model_edge();
        logic lk;
        logic dn;
        int   nph;
        lk = lk2; dn = dn2; nph = ph;
        lk2 = lk1; lk1 = bus.ddr_pll_lock;
        dn2 = dn1; dn1 = bus.cfg_done;
        cyc++;
        if (ph >= 1 && ph <= 5 && !bus.init_start) nph = 0;
        else begin
            case (ph)
                0: if (bus.init_start) begin nph = 1; m_errf = 1'b0; m_err = 2'd0; end
                1: if (cyc - t_ent == P) nph = 2;
                2: if (lk) nph = 3;
                   else if (TO_EN && cyc - t_ent == LT) begin nph = 6; m_err = 2'd1; end
                3: if (cyc - t_ent == H) nph = 4;
                4: if (dn) nph = 5;
                   else if (TO_EN && cyc - t_ent == CT) begin nph = 6; m_err = 2'd2; end
                5: if (!lk) begin nph = 6; m_err = 2'd3; end
                6: if (!bus.init_start) nph = 0;
                default: ;
            endcase
        end
        if (nph == 6 && ph != 6) m_errf = 1'b1;
        if (nph != ph) t_ent = cyc;
        ph = nph;
    endtask

    function automatic logic [16:0] exp_vec();
        logic pll, core, cw, rdy;
        pll  = (ph >= 2 && ph <= 5);
        core = (ph >= 3 && ph <= 5);
        cw   = (ph == 4 || ph == 5);
        rdy  = (ph == 5);
        return {pll, core, core, ~cw, (ph == 4), 1'b0, rdy, rdy, rdy, rdy, m_errf, m_err, 4'(ph)};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.ddr_pll_rstn, bus.phy_rstn, bus.ctrl_rstn, bus.cfg_reset, bus.cfg_start,
                bus.cfg_sel, bus.regARESETn, bus.axi0_ARESETn, bus.axi1_ARESETn, bus.init_done,
                bus.init_error, bus.err_code, bus.state_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check("outputs_vs_model", 32'(dut_vec()), 32'(exp_vec()));
        end
    endtask

    function automatic logic [3:0] sig(input int sel);
        case (sel)
            0:       return {3'b0, bus.ddr_pll_rstn};
            1:       return {3'b0, bus.phy_rstn};
            2:       return {3'b0, bus.cfg_start};
            3:       return {3'b0, bus.init_done};
            4:       return {3'b0, bus.regARESETn};
            default: return bus.state_o;
        endcase
    endfunction

    // Steps until the selected output reaches val; an expired budget is a failed check.
    task automatic count_until(input string tag, input int sel, input logic [3:0] val,
                               input int limit, output int n);
        n = 0;
        while (sig(sel) !== val && n < limit) begin
            step(1);
            n++;
        end
        check(tag, 32'(sig(sel)), 32'(val));
    endtask

    initial begin
        int n;
        cyc = 0;
        rst = 1'b1;
        bus.init_start = 1'b0; bus.ddr_pll_lock = 1'b0; bus.cfg_done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_values", 32'(dut_vec()), 32'(exp_vec()));
        check("reset_cfg_reset", 32'(bus.cfg_reset), 32'd1);
        rst = 1'b0;
        step(3);

        // Normal bring-up with the directed delays.
        bus.init_start = 1'b1;
        step(1);
        check("start_state", 32'(bus.state_o), 32'd1);
        count_until("pll_rstn_rise", 0, 4'd1, 50, n);
        check("pll_rstn_latency", n, P);
        step(10);
        bus.ddr_pll_lock = 1'b1;
        count_until("phy_rstn_rise", 1, 4'd1, 50, n);
        check("lock_to_phy_latency", n, 3);
        check("ctrl_rstn_with_phy", 32'(bus.ctrl_rstn), 32'd1);
        count_until("cfg_start_rise", 2, 4'd1, 50, n);
        check("phy_to_cfg_start", n, H);
        check("cfg_reset_low", 32'(bus.cfg_reset), 32'd0);
        step(20);
        bus.cfg_done = 1'b1;
        count_until("init_done_rise", 3, 4'd1, 50, n);
        check("done_to_ready", n, 3);
        check("ready_err_code", 32'(bus.err_code), 32'd0);
        check("ready_state", 32'(bus.state_o), 32'd5);
        check("ready_axi1", 32'(bus.axi1_ARESETn), 32'd1);

        // Lock lost while READY.
        bus.ddr_pll_lock = 1'b0;
        count_until("axi_drop", 4, 4'd0, 20, n);
        check("lock_loss_latency", n, 3);
        check("lock_loss_code", 32'(bus.err_code), 32'd3);
        check("lock_loss_flag", 32'(bus.init_error), 32'd1);

        // Retry: low then high on init_start clears the error.
        bus.cfg_done = 1'b0;
        bus.init_start = 1'b0;
        step(1);
        check("error_to_idle", 32'(bus.state_o), 32'd0);
        check("error_sticky_in_idle", 32'(bus.init_error), 32'd1);
        bus.init_start = 1'b1;
        step(1);
        check("retry_clears_flag", 32'(bus.init_error), 32'd0);
        check("retry_clears_code", 32'(bus.err_code), 32'd0);
        count_until("retry_pll", 0, 4'd1, 50, n);
        step($urandom_range(0, 30));
        bus.ddr_pll_lock = 1'b1;
        count_until("retry_cfg_start", 2, 4'd1, 100, n);
        step($urandom_range(0, 30));
        bus.cfg_done = 1'b1;
        count_until("retry_ready", 5, 4'd5, 50, n);
        check("retry_init_done", 32'(bus.init_done), 32'd1);

        // Abort from READY, then abort mid-CFG_WAIT.
        bus.init_start = 1'b0;
        bus.cfg_done = 1'b0;
        step(1);
        check("abort_ready_state", 32'(bus.state_o), 32'd0);
        check("abort_ready_noerr", 32'(bus.init_error), 32'd0);
        bus.init_start = 1'b1;
        count_until("reach_cfg_wait", 5, 4'd4, 100, n);
        step($urandom_range(1, 5));
        bus.init_start = 1'b0;
        step(1);
        check("abort_cfg_state", 32'(bus.state_o), 32'd0);
        check("abort_cfg_phy", 32'(bus.phy_rstn), 32'd0);
        check("abort_cfg_noerr", 32'(bus.init_error), 32'd0);

        // Asynchronous reset mid-RST_REL takes effect without a clock edge.
        bus.init_start = 1'b1;
        count_until("reach_rst_rel", 5, 4'd3, 100, n);
        step(2);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset_values", 32'(dut_vec()), 32'(exp_vec()));
        check("async_reset_phy", 32'(bus.phy_rstn), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_held", 32'(dut_vec()), 32'(exp_vec()));
        rst = 1'b0;
        step(1);
        check("restart_after_reset", 32'(bus.state_o), 32'd1);
        bus.init_start = 1'b0;
        step(2);

`ifdef DDR_INIT_TIMEOUT_EN
        bus.ddr_pll_lock = 1'b0;
        bus.init_start = 1'b1;
        count_until("reach_pll_lock", 5, 4'd2, 50, n);
        count_until("lock_timeout", 5, 4'd6, LT + 10, n);
        check("lock_timeout_cycles", n, LT);
        check("lock_timeout_code", 32'(bus.err_code), 32'd1);
        check("lock_timeout_pll_rstn", 32'(bus.ddr_pll_rstn), 32'd0);
        bus.init_start = 1'b0;
        step(1);
        bus.ddr_pll_lock = 1'b1;
        bus.init_start = 1'b1;
        count_until("reach_cfg_wait2", 5, 4'd4, 100, n);
        count_until("cfg_timeout", 5, 4'd6, CT + 10, n);
        check("cfg_timeout_cycles", n, CT);
        check("cfg_timeout_code", 32'(bus.err_code), 32'd2);
        check("cfg_timeout_start", 32'(bus.cfg_start), 32'd0);
        check("cfg_timeout_phy", 32'(bus.phy_rstn), 32'd0);
        bus.init_start = 1'b0;
        step(2);
`else
        bus.ddr_pll_lock = 1'b0;
        bus.init_start = 1'b1;
        count_until("reach_pll_lock", 5, 4'd2, 50, n);
        step(1000);
        check("no_timeout_state", 32'(bus.state_o), 32'd2);
        check("no_timeout_flag", 32'(bus.init_error), 32'd0);
        bus.init_start = 1'b0;
        step(2);
`endif

        // Randomized bring-ups, optionally losing lock once ready.
        for (int it = 0; it < 4; it++) begin
            bus.ddr_pll_lock = 1'b0;
            bus.cfg_done = 1'b0;
            bus.init_start = 1'b1;
            count_until("rnd_pll_lock", 5, 4'd2, 50, n);
            step($urandom_range(0, 40));
            bus.ddr_pll_lock = 1'b1;
            count_until("rnd_cfg_wait", 5, 4'd4, 100, n);
            step($urandom_range(0, 40));
            bus.cfg_done = 1'b1;
            count_until("rnd_ready", 5, 4'd5, 50, n);
            step($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                bus.ddr_pll_lock = 1'b0;
                step(4);
                check("rnd_lock_loss_code", 32'(bus.err_code), 32'd3);
            end
            bus.init_start = 1'b0;
            step(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
